// File: rtl/mudi_unit.sv
// HI/LO multiply/divide unit for the EX stage: computes the full result at issue,
// then holds it for MULT_CYCLES/DIV_CYCLES before committing to HI/LO.
module mudi_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mudiOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        sel,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   pend;
  logic          pend_wr;

  logic          is_signed, neg_a, neg_b, div_zero;
  logic [31:0]   ua, ub, dvs, uq, ur, q, r;
  logic [63:0]   ext_a, ext_b, prod, res;

  // One shared multiplier and one unsigned divider; signedness handled by
  // sign-extension for multiply and magnitude/sign fix-up for divide.
  always_comb begin
    is_signed = ~mudiOp[0];
    neg_a     = is_signed & srcA[31];
    neg_b     = is_signed & srcB[31];
    ext_a     = {{32{neg_a}}, srcA};
    ext_b     = {{32{neg_b}}, srcB};
    prod      = ext_a * ext_b;
    ua        = neg_a ? -srcA : srcA;
    ub        = neg_b ? -srcB : srcB;
    dvs       = (ub == 32'd0) ? 32'd1 : ub;
    uq        = ua / dvs;
    ur        = ua % dvs;
    q         = (neg_a ^ neg_b) ? -uq : uq;
    r         = neg_a ? -ur : ur;
    res       = mudiOp[1] ? {r, q} : prod;
    div_zero  = mudiOp[1] & (srcB == 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          case (mudiOp)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              pend    <= res;
              pend_wr <= ~div_zero;
              cnt     <= mudiOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy    <= 1'b1;
              state   <= BUSY;
            end
            3'b100:  hi <= srcA;
            3'b101:  lo <= srcA;
            default: ;
          endcase
        end
        BUSY: begin
          // Issue attempts while busy are dropped; the hazard unit never sends them.
          if (cnt == CW'(1)) begin
            if (pend_wr) {hi, lo} <= pend;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign occupied = start | busy;
  assign result   = sel ? hi : lo;
endmodule

// File: tb/tb_mudi_unit.sv
// Directed + randomized bench for mudi_unit against an arithmetic HI/LO model.
module tb_mudi_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mudiOp = 3'd0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        sel = 1'b0;
  logic        busy, occupied;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mudi_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mudiOp(mudiOp), .srcA(srcA),
    .srcB(srcB), .sel(sel), .busy(busy), .occupied(occupied), .result(result),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one request and follows it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    logic        upd;
    logic [31:0] nh, nl;
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    upd = 1'b1; nh = mhi; nl = mlo; n = 0;
    case (op)
      3'd0: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; n = 5; end
      3'd1: begin up = {32'h0, a} * {32'h0, b}; nh = up[63:32]; nl = up[31:0]; n = 5; end
      3'd2: begin
        n = 10;
        if (b == 0) upd = 1'b0;
        else begin sq = sa / sb; sr = sa % sb; nl = sq[31:0]; nh = sr[31:0]; end
      end
      3'd3: begin
        n = 10;
        if (b == 0) upd = 1'b0;
        else begin nl = a / b; nh = a % b; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: upd = 1'b0;
    endcase
    start = 1'b1; mudiOp = op; srcA = a; srcB = b; sel = 1'($urandom);
    #1;
    chk("occupied_issue", {31'b0, occupied}, 32'd1);
    chk("result_issue", result, sel ? mhi : mlo);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_during", {31'b0, busy}, 32'd1);
      chk("occupied_during", {31'b0, occupied}, 32'd1);
      chk("hi_hold", hi, mhi);
      chk("lo_hold", lo, mlo);
      srcA = $urandom; srcB = $urandom;
      if (noise) begin start = 1'($urandom); mudiOp = 3'($urandom); end
      @(negedge clk);
      start = 1'b0;
    end
    if (upd) begin mhi = nh; mlo = nl; end
    #1;
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("occupied_done", {31'b0, occupied}, 32'd0);
    chk("hi_done", hi, mhi);
    chk("lo_done", lo, mlo);
  endtask

  initial begin
    logic [31:0] rb;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    sel = 1'b1; #1;
    chk("mult_mfhi", result, 32'hFFFFFFFF);

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("divu_lo", lo, 32'h7FFFFFFC);
    chk("divu_hi", hi, 32'd1);

    run_op(3'd4, 32'h1234, 32'd0, 1'b0);
    run_op(3'd5, 32'h5678, 32'd0, 1'b0);
    run_op(3'd2, 32'd99, 32'd0, 1'b0);
    chk("divz_hi", hi, 32'h1234);
    chk("divz_lo", lo, 32'h5678);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);

    run_op(3'd4, 32'hAAAA5555, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'hAAAA5555);
    chk("mthi_lo", lo, 32'h80000000);
    run_op(3'd6, 32'hDEADBEEF, 32'd5, 1'b0);
    chk("illegal_hi", hi, 32'hAAAA5555);

    // Back-to-back issue with noise, special and zero divisors mixed in.
    repeat (40) begin
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'd1;
        default: rb = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
             rb, 1'b1);
      sel = 1'($urandom); #1;
      chk("rand_result", result, sel ? mhi : mlo);
    end

    start = 1'b1; mudiOp = 3'd0; srcA = 32'd3; srcB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    mhi = '0; mlo = '0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, mhi);
    chk("abort_lo", lo, mlo);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_late_lo", lo, mlo);
    chk("abort_late_hi", hi, mhi);
    chk("abort_late_busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mudi_unit.md
Name: mudi_unit

Overview:
- Multiply/divide responder in the EX stage of the P6 pipeline.
- Consumes the decoder's isStart/mudiOp/MUDI_sel request encoding and owns the HI/LO registers.
- Models the multi-cycle latency of mult/div with a busy counter. The pipeline stalls on it for any later multiply/divide or HI/LO access.
- Serves the mfhi/mflo read path via a combinational read mux.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu
- DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  isStart from decoder, E-stage; request valid this cycle
- mudiOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others ignored
- srcA  input  32  forwarded rs value
- srcB  input  32  forwarded rt value
- sel  input  1  MUDI_sel: 0 read LO, 1 read HI
- busy  output  1  multi-cycle operation in progress
- occupied  output  1  start | busy, combinational; the hazard unit uses it for stall
- result  output  32  sel ? HI : LO, combinational
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Clears HI, LO, counter and pending-op state to 0; busy = 0.
  - A reset asserted mid-operation aborts it. No HI/LO update occurs afterwards.
- Internal state:
  - IDLE/BUSY FSM, a down-counter sized for max(MULT_CYCLES, DIV_CYCLES), latched op, and latched 64-bit pending result.
- IDLE, start sampled at edge k with mudiOp 000–011:
  - Compute the full result from srcA/srcB at edge k and latch it.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); FSM goes to BUSY.
  - busy is high for exactly N cycles after edge k.
  - At edge k+N: HI/LO take the pending result, busy falls, FSM returns to IDLE.
- Operand latching: later changes to srcA/srcB have no effect once the operation has started.
- mult: {HI,LO} = $signed(srcA) * $signed(srcB), 64-bit.
- multu: {HI,LO} = srcA * srcB, unsigned 64-bit.
- div, signed (truncate toward zero):
  - LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- divu: LO = srcA / srcB, HI = srcA % srcB, unsigned.
- Divide by zero (srcB == 0 for div/divu):
  - Busy timing is normal.
  - HI and LO are left unchanged at completion.
- mthi / mtlo:
  - Single cycle; HI (or LO) = srcA at edge k.
  - busy is never asserted.
  - Overwrites the register only; the other register is untouched.
- Illegal mudiOp (110, 111) with start: no state change.
- start while busy:
  - Ignored, because the hazard unit guarantees no issue while occupied.
  - The RTL must not restart or corrupt the pending operation.
- result/hi/lo:
  - Reflect the committed registers only; the pending result is never visible early.
  - While busy, HI/LO hold their pre-operation values.
- Back-to-back operations:
  - A start in the cycle immediately after busy falls is accepted normally.
  - mfhi in that same cycle reads the new value.

Test Plan:
- Reset, then mult: reset, then srcA=0xFFFFFFFE (−2), srcB=3, mudiOp=000, start 1 cycle → busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; result with sel=1 → 0xFFFFFFFF.
- multu, operand latching: srcA=0xFFFFFFFF, srcB=0xFFFFFFFF, start; change srcA to 0 during busy → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div and divu: div srcA=−7 (0xFFFFFFF9), srcB=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu same operands → LO=0x7FFFFFFC, HI=1.
- Divide by zero and overflow:
  - Preload via mthi 0x1234, mtlo 0x5678; div by 0 → after 10 cycles HI=0x1234, LO=0x5678.
  - Then div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi/mtlo and occupied: mthi srcA=0xAAAA5555 → HI updates at the next edge, busy never rises, occupied high only during the start cycle, LO unchanged.
- Reset mid-operation: start mult 3×4, assert reset at cycle 2 of busy → busy=0, HI=LO=0 immediately (asynchronous); after release, no late update to LO=12.
